// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory-dump engine.
package mem_dump_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LATCH  = 3'd2,
    SEND   = 3'd3,
    GAP    = 3'd4,
    NEXT   = 3'd5,
    FINISH = 3'd6
  } state_e;

endpackage

// File: rtl/mem_dump.sv
// Streams a block of 32-bit memory words out through a byte UART transmitter,
// least-significant byte first, one word per 11 cycles when the transmitter is always ready.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_dout,
  output logic              tx_wr,
  output logic [7:0]        tx_din,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_W-1:0]     r_base;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_idx;
  logic [CNT_W-1:0]      w_idx_inc;
  logic [BYTE_IDX_W-1:0] r_byte;
  logic [31:0]           r_shift;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_accept;

  // Index is compared after increment but before it can wrap, so a full-range count terminates.
  assign w_idx_inc = r_idx + CNT_W'(1);
  assign mem_addr  = r_base + ADDR_W'({r_idx, 2'b00});
  assign tx_din    = r_shift[7:0];
  assign busy      = r_busy;
  assign done      = r_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and strobe outputs.
  always_comb begin
    w_state_next = r_state;
    mem_rd       = 1'b0;
    tx_wr        = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (word_count == '0) ? FINISH : READ;
        end
      end
      READ: begin
        mem_rd       = 1'b1;
        w_state_next = LATCH;
      end
      LATCH: w_state_next = SEND;
      SEND: begin
        if (tx_ready) begin
          tx_wr        = 1'b1;
          w_state_next = GAP;
        end
      end
      GAP: begin
        w_state_next = (r_byte == BYTE_IDX_W'(BYTES_PER_WORD - 1)) ? NEXT : SEND;
      end
      NEXT:    w_state_next = (w_idx_inc == r_cnt) ? FINISH : READ;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // No strobes may escape during the reset cycle itself.
    if (reset) begin
      mem_rd = 1'b0;
      tx_wr  = 1'b0;
    end
  end

  // Datapath: latched parameters, word/byte indices, byte shifter, busy/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      if (w_accept) begin
        r_base <= base_addr;
        r_cnt  <= word_count;
        r_idx  <= '0;
        r_byte <= '0;
        r_busy <= 1'b1;
      end
      if (r_state == LATCH) begin
        r_shift <= mem_dout;
      end
      if (r_state == GAP) begin
        r_shift <= r_shift >> 8;
        r_byte  <= r_byte + BYTE_IDX_W'(1);
      end
      if (r_state == NEXT) begin
        r_idx <= w_idx_inc;
      end
      // busy falls in the same cycle that done rises.
      if (r_state == FINISH) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of mem_addr and base_addr.
REQ-002 SHALL have parameter CNT_W, default 16, width of word_count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a dump.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: byte address of the first word, sampled on accepted start.
REQ-007 SHALL have port word_count, input, CNT_W bits: number of 32-bit words to dump, sampled on accepted start.
REQ-008 SHALL have port mem_addr, output, ADDR_W bits: byte address presented to the memory read port.
REQ-009 SHALL have port mem_rd, output, 1 bit: one-cycle read strobe.
REQ-010 SHALL have port mem_dout, input, 32 bits: read data, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have port tx_wr, output, 1 bit: one-cycle byte-send strobe to the byte UART transmitter.
REQ-012 SHALL have port tx_din, output, 8 bits: byte to send, valid while tx_wr=1.
REQ-013 SHALL have port tx_ready, input, 1 bit: the transmitter is idle and can accept a byte.
REQ-014 SHALL have port busy, output, 1 bit: high from accepted start until done.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the dump completes.

Function
REQ-016 SHALL implement the states IDLE, READ, LATCH, SEND, GAP, NEXT, FINISH.
REQ-017 IDLE: start=1 SHALL latch base_addr and word_count, zero the word index and byte index, and set busy=1. If word_count=0 the next state SHALL be FINISH, otherwise READ.
REQ-018 READ: SHALL assert mem_rd for exactly 1 cycle with mem_addr = base + 4*index (modulo 2^ADDR_W, wrapping silently), then go to LATCH.
REQ-019 LATCH: SHALL capture mem_dout into a 32-bit shift register, then go to SEND.
REQ-020 SEND: while tx_ready=1, SHALL assert tx_wr for 1 cycle with tx_din = the shift register's bits [7:0] and go to GAP; while tx_ready=0 it SHALL hold in SEND with tx_wr=0.
REQ-021 Byte order SHALL be little-endian (bits 7:0 first, 31:24 last), mirroring the loader's byte packing.
REQ-022 GAP: SHALL ignore tx_ready for exactly 1 cycle and shift the register right by 8. If fewer than 4 bytes have been sent it SHALL return to SEND, otherwise go to NEXT.
REQ-023 NEXT: SHALL increment the word index. If the index equals word_count it SHALL go to FINISH, otherwise READ.
REQ-024 FINISH: SHALL pulse done for 1 cycle, drop busy in the same cycle, and go to IDLE.
REQ-025 start while busy=1 SHALL be ignored, and the latched parameters SHALL stay unchanged.
REQ-026 tx_wr and mem_rd SHALL never be high in the same cycle, and tx_wr SHALL never be high on two consecutive cycles.
REQ-027 A word_count of 2^CNT_W-1 SHALL complete without the index overflowing, because the index is CNT_W bits and is compared before it wraps.
REQ-028 Minimum throughput SHALL be 1 word per 11 cycles when tx_ready is held at 1.

Reset
REQ-029 On reset=1, on any clock, the state SHALL become IDLE, and busy, done, mem_rd and tx_wr SHALL be 0.
REQ-030 On reset, mem_addr, tx_din and the shift register SHALL be 0.
REQ-031 Reset mid-dump SHALL abandon the dump with no further mem_rd or tx_wr, and SHALL NOT generate a done pulse.
REQ-032 The first cycle after reset is released SHALL accept start.

Structure
REQ-033 The state enum and the constant BYTES_PER_WORD=4 SHALL live in package mem_dump_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the byte shifter is inline.

Verification
REQ-035 Bench SHALL cover: base=0x0, count=1, mem[0]=0x44332211, tx_ready=1 -> one mem_rd at addr 0x0, then tx_din 0x11, 0x22, 0x33, 0x44 in order, done 1 pulse, busy low afterwards.
REQ-036 Bench SHALL cover: base=0x100, count=3, tx_ready=1 -> mem_rd at 0x100, 0x104, 0x108 and 12 tx_wr pulses, with no back-to-back tx_wr.
REQ-037 Bench SHALL cover: count=0 -> no mem_rd, no tx_wr, and done 2 cycles after start.
REQ-038 Bench SHALL cover: tx_ready held low for 50 cycles during SEND -> no tx_wr during the stall, and the byte is sent on the first cycle tx_ready=1.
REQ-039 Bench SHALL cover: a second start asserted mid-dump with base=0x200 -> ignored, and all addresses stay derived from the original base.
REQ-040 Bench SHALL cover: reset asserted after the 2nd byte of word 0 -> next cycle tx_wr=0 and busy=0, no done pulse, and a following start with count=1 dumps correctly.
